// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared CPU definitions for the exception unit: FSM states,
//               exception cause codes, default handler vectors and the
//               cause-to-vector lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

  // Exception sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Cause codes as seen on exc_cause
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_OPCODE = 2'd1,
    CAUSE_OVF    = 2'd2,
    CAUSE_DIV0   = 2'd3
  } cause_t;

  // Default handler vector byte addresses
  localparam logic [31:0] c_vec_opcode = 32'd253;
  localparam logic [31:0] c_vec_ovf    = 32'd254;
  localparam logic [31:0] c_vec_div0   = 32'd255;

  // Fixed priority: opcode beats overflow beats divide-by-zero
  function automatic cause_t pick_cause(input logic opcode, input logic ovf,
                                        input logic div0);
    if (opcode)    return CAUSE_OPCODE;
    else if (ovf)  return CAUSE_OVF;
    else if (div0) return CAUSE_DIV0;
    else           return CAUSE_NONE;
  endfunction

  // Handler vector for a cause; CAUSE_NONE maps to address 0
  function automatic logic [31:0] vec_for(input cause_t c,
                                          input logic [31:0] v_opcode,
                                          input logic [31:0] v_ovf,
                                          input logic [31:0] v_div0);
    case (c)
      CAUSE_OPCODE: return v_opcode;
      CAUSE_OVF:    return v_ovf;
      CAUSE_DIV0:   return v_div0;
      default:      return 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : exception_unit
// Description : Exception sequencer. On an exception trigger it saves the
//               faulting PC to EPC, fetches the handler vector byte from
//               memory and loads it into the PC, stalling the core while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE  = c_vec_opcode,
  parameter logic [31:0] VEC_OVF     = c_vec_ovf,
  parameter logic [31:0] VEC_DIV0    = c_vec_div0,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic [31:0] instr_pc,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd_req,
  output logic        epc_load,
  output logic [31:0] epc_value,
  output logic        pc_load,
  output logic [31:0] pc_value,
  output logic [1:0]  exc_cause,
  output logic        busy,
  output logic        done
);

  // Final WAIT count: WAIT spans MEM_LATENCY cycles starting at count 0
  localparam logic [2:0] c_wait_last = 3'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pcv_q, pcv_d;
  logic [2:0]  cnt_q, cnt_d;
  cause_t      trig_cause;

  assign trig_cause = pick_cause(exc_opcode, exc_overflow, exc_divzero);

  // State, captured context and WAIT counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      epc_q   <= 32'h0;
      pcv_q   <= 32'h0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      pcv_q   <= pcv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; triggers are only looked at in IDLE
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    pcv_d   = pcv_q;
    cnt_d   = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (trig_cause != CAUSE_NONE) begin
          state_d = ST_SAVE;
          cause_d = trig_cause;
          epc_d   = instr_pc;
        end
      end
      ST_SAVE: state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_q == c_wait_last) begin
          state_d = ST_LOAD;
          // Vector table holds byte handler addresses; masking zero-extends
          pcv_d   = mem_rdata & 32'h0000_00FF;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state; memory address is gated
  always_comb begin
    mem_rd_req = 1'b0;
    mem_addr   = 32'h0;
    epc_load   = 1'b0;
    pc_load    = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_SAVE: epc_load = 1'b1;
      ST_REQ, ST_WAIT: begin
        mem_rd_req = 1'b1;
        mem_addr   = vec_for(cause_q, VEC_OPCODE, VEC_OVF, VEC_DIV0);
      end
      ST_LOAD: pc_load = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

  assign epc_value = epc_q;
  assign pc_value  = pcv_q;
  assign exc_cause = cause_q;

endmodule
`default_nettype wire

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter VEC_OPCODE, default 253, is the byte address of the invalid-opcode handler vector.
REQ-002 Parameter VEC_OVF, default 254, is the byte address of the overflow handler vector.
REQ-003 Parameter VEC_DIV0, default 255, is the byte address of the divide-by-zero handler vector.
REQ-004 Parameter MEM_LATENCY, default 1, is the number of cycles from address valid to read data valid (range 1..7).
REQ-005 Port clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-006 Port reset  input  1  is the reset, asynchronous and active-high.
REQ-007 Port exc_opcode  input  1  is a one-cycle pulse flagging an invalid opcode.
REQ-008 Port exc_overflow  input  1  is a one-cycle pulse flagging ALU overflow.
REQ-009 Port exc_divzero  input  1  is a one-cycle pulse flagging a divide by zero.
REQ-010 Port instr_pc  input  32  is the address of the faulting instruction.
REQ-011 Port mem_rdata  input  32  is the memory read data.
REQ-012 Port mem_addr  output  32  is the vector address presented to memory.
REQ-013 Port mem_rd_req  output  1  requests memory access and selects mem_addr onto the memory address mux.
REQ-014 Port epc_load  output  1  is the one-cycle EPC write enable.
REQ-015 Port epc_value  output  32  is the data for EPC.
REQ-016 Port pc_load  output  1  is the one-cycle PC write enable.
REQ-017 Port pc_value  output  32  is the handler address for PC.
REQ-018 Port exc_cause  output  2  is the cause code: 0 none, 1 opcode, 2 overflow, 3 div0.
REQ-019 Port busy  output  1  is high in every state except IDLE; the control unit stalls while it is high.
REQ-020 Port done  output  1  is a one-cycle pulse marking completion.

Function
REQ-021 The FSM SHALL have states IDLE, SAVE, REQ, WAIT, LOAD and DONE.
REQ-022 In IDLE, any trigger sampled high SHALL move the FSM to SAVE and register instr_pc and exc_cause.
REQ-023 Simultaneous triggers SHALL be prioritised opcode > overflow > div0; lower-priority triggers are discarded.
REQ-024 SAVE SHALL last one cycle, with epc_load=1 and epc_value=the registered instr_pc; the next state is REQ.
REQ-025 REQ SHALL last one cycle, with mem_rd_req=1 and mem_addr=the vector for the registered cause; the next state is WAIT.
REQ-026 WAIT SHALL last exactly MEM_LATENCY cycles, counted by a 3-bit counter, with mem_rd_req and mem_addr held.
REQ-027 On the last WAIT edge, mem_rdata[7:0] SHALL be zero-extended to 32 bits and registered as pc_value.
REQ-028 LOAD SHALL last one cycle, with pc_load=1; the next state is DONE.
REQ-029 DONE SHALL last one cycle, with done=1; the next state is IDLE, and exc_cause holds its value until the next exception.
REQ-030 Triggers arriving while busy=1 SHALL be ignored.
REQ-031 mem_addr SHALL be 0 whenever mem_rd_req=0.
REQ-032 Latency SHALL be fixed: with the trigger at edge 0, epc_load is high in cycle 1, pc_load in cycle 3+MEM_LATENCY, and done in cycle 4+MEM_LATENCY.
REQ-033 The block SHALL not write memory.

Reset
REQ-034 reset=1 SHALL force IDLE immediately, regardless of current state.
REQ-035 During reset, all outputs SHALL be 0, exc_cause=0 and the WAIT counter=0.
REQ-036 A reset mid-sequence SHALL abort the sequence with no further epc_load or pc_load.
REQ-037 Triggers present on the first edge after reset deassertion SHALL be honoured.

Structure
REQ-038 State encodings, cause codes and the default vector constants SHALL live in the shared package cpu_defs_pkg.
REQ-039 The block SHALL be one module with no sub-module; the WAIT counter is inline.
REQ-040 In cpu, the block's outputs SHALL drive the EPC, the PC mux and the address mux select inputs.

Verification
REQ-041 exc_overflow pulse, instr_pc=0x0000_0040, mem_rdata[7:0]=0x80 -> epc_load cycle 1 with epc_value 0x40; mem_addr 254; pc_load cycle 4 with pc_value 0x0000_0080; done cycle 5; exc_cause 2.
REQ-042 exc_opcode and exc_divzero in the same cycle -> mem_addr 253, exc_cause 1, exactly one sequence.
REQ-043 MEM_LATENCY=3 with exc_divzero -> mem_addr 255 held for 4 cycles; pc_load cycle 6; done cycle 7.
REQ-044 exc_overflow pulse during WAIT -> ignored, no second epc_load, busy drops after done.
REQ-045 reset asserted while in WAIT -> all outputs 0 asynchronously; no pc_load follows; a new trigger after release runs a full sequence.
REQ-046 mem_rdata=0xFFFF_FF12 -> pc_value 0x0000_0012, with upper bits ignored.
